// File: rtl/cmp_pkg.sv
// Shared codes, mode encodings and FSM state type for the N-channel comparator.
package cmp_pkg;

    localparam logic [1:0] RES_EQ  = 2'b00;
    localparam logic [1:0] RES_LT  = 2'b01;
    localparam logic [1:0] RES_GT  = 2'b10;
    localparam logic [1:0] RES_INV = 2'b11;

    localparam logic [1:0] MODE_SIGN = 2'b00;
    localparam logic [1:0] MODE_REF  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMP,
        PRESENT,
        DONE
    } state_t;

    // Any encoding other than SIGN or REF is reserved.
    function automatic logic mode_reserved(input logic [1:0] m);
        return (m != MODE_SIGN) && (m != MODE_REF);
    endfunction

endpackage

// File: rtl/cmp_cell.sv
// Combinational three-way compare of a against b; signedness fixed at elaboration.
module cmp_cell
    import cmp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          SIGNED = 1'b1
)(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [1:0]        code_c
);

    always_comb begin
        code_c = RES_EQ;
        if (SIGNED) begin
            if ($signed(a) < $signed(b)) begin
                code_c = RES_LT;
            end else if ($signed(a) > $signed(b)) begin
                code_c = RES_GT;
            end
        end else begin
            if (a < b) begin
                code_c = RES_LT;
            end else if (a > b) begin
                code_c = RES_GT;
            end
        end
    end

endmodule

// File: rtl/cmp_array_seq.sv
// N-channel sequential comparator: one channel classified per cycle, running min/max
// index tracking, result held under an out_rdy/out_ack handshake.
module cmp_array_seq
    import cmp_pkg::*;
#(
    parameter int unsigned  DATA_W = 8,
    parameter int unsigned  N_CH   = 4,
    parameter bit           SIGNED = 1'b1,
    localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_rdy,
    input  logic [1:0]               mode,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic [DATA_W-1:0]        ref_in,
    input  logic                     out_ack,
    output logic                     busy,
    output logic                     out_rdy,
    output logic [2*N_CH-1:0]        result,
    output logic [IDX_W-1:0]         min_idx,
    output logic [IDX_W-1:0]         max_idx,
    output logic                     err,
    output logic                     done
);

    state_t                   state_q, state_d;
    logic [N_CH*DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]        ref_q, ref_d;
    logic [1:0]               mode_q, mode_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        min_val_q, min_val_d;
    logic [DATA_W-1:0]        max_val_q, max_val_d;

    logic                     busy_d, out_rdy_d, err_d, done_d;
    logic [2*N_CH-1:0]        result_d;
    logic [IDX_W-1:0]         min_idx_d, max_idx_d;

    logic [DATA_W-1:0]        ch_sel_c;
    logic [DATA_W-1:0]        cls_b_c;
    logic [1:0]               cls_code_c, min_code_c, max_code_c;

    // Channel selected by the running counter.
    always_comb begin
        ch_sel_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_q == IDX_W'(i)) begin
                ch_sel_c = data_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cls_b_c = (mode_q == MODE_REF) ? ref_q : DATA_W'(0);

    cmp_cell #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cls (
        .a      (ch_sel_c),
        .b      (cls_b_c),
        .code_c (cls_code_c)
    );

    // The running min and max each need their own strict compare every cycle.
    cmp_cell #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_min (
        .a      (ch_sel_c),
        .b      (min_val_q),
        .code_c (min_code_c)
    );

    cmp_cell #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_max (
        .a      (ch_sel_c),
        .b      (max_val_q),
        .code_c (max_code_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ref_d     = ref_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        min_val_d = min_val_q;
        max_val_d = max_val_q;
        result_d  = result;
        min_idx_d = min_idx;
        max_idx_d = max_idx;
        err_d     = err;
        out_rdy_d = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_rdy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d    = data_in;
                ref_d     = ref_in;
                mode_d    = mode;
                cnt_d     = '0;
                min_val_d = data_in[DATA_W-1:0];
                max_val_d = data_in[DATA_W-1:0];
                min_idx_d = '0;
                max_idx_d = '0;
                state_d   = CMP;
            end
            CMP: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (cnt_q == IDX_W'(i)) begin
                        result_d[2*i +: 2] = mode_reserved(mode_q) ? RES_INV : cls_code_c;
                    end
                end
                if (min_code_c == RES_LT) begin
                    min_val_d = ch_sel_c;
                    min_idx_d = cnt_q;
                end
                if (max_code_c == RES_GT) begin
                    max_val_d = ch_sel_c;
                    max_idx_d = cnt_q;
                end
                if (cnt_q == IDX_W'(N_CH - 1)) begin
                    state_d   = PRESENT;
                    out_rdy_d = 1'b1;
                    err_d     = mode_reserved(mode_q);
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            PRESENT: begin
                if (out_ack) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    result_d  = '0;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    err_d     = 1'b0;
                end else begin
                    out_rdy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            ref_q     <= '0;
            mode_q    <= '0;
            cnt_q     <= '0;
            min_val_q <= '0;
            max_val_q <= '0;
            busy      <= 1'b0;
            out_rdy   <= 1'b0;
            result    <= '0;
            min_idx   <= '0;
            max_idx   <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ref_q     <= ref_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            min_val_q <= min_val_d;
            max_val_q <= max_val_d;
            busy      <= busy_d;
            out_rdy   <= out_rdy_d;
            result    <= result_d;
            min_idx   <= min_idx_d;
            max_idx   <= max_idx_d;
            err       <= err_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_cmp_array_seq.sv
// Scoreboard bench for cmp_array_seq: signed N_CH=4, unsigned N_CH=4 and signed N_CH=1 builds.
module tb_cmp_array_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sh_mode;
    logic [31:0] sh_data;
    logic [7:0]  sh_ref;
    logic        out_ack;
    logic [2:0]  in_rdy_v;

    logic       b0, r0, e0, d0, b1, r1, e1, d1, b2, r2, e2, d2;
    logic [7:0] res0, res1;
    logic [1:0] res2;
    logic [1:0] mn0, mx0, mn1, mx1;
    logic [0:0] mn2, mx2;

    always #5 clk = ~clk;

    cmp_array_seq #(.DATA_W(8), .N_CH(4), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .in_rdy(in_rdy_v[0]), .mode(sh_mode), .data_in(sh_data),
        .ref_in(sh_ref), .out_ack(out_ack), .busy(b0), .out_rdy(r0), .result(res0),
        .min_idx(mn0), .max_idx(mx0), .err(e0), .done(d0));

    cmp_array_seq #(.DATA_W(8), .N_CH(4), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst), .in_rdy(in_rdy_v[1]), .mode(sh_mode), .data_in(sh_data),
        .ref_in(sh_ref), .out_ack(out_ack), .busy(b1), .out_rdy(r1), .result(res1),
        .min_idx(mn1), .max_idx(mx1), .err(e1), .done(d1));

    cmp_array_seq #(.DATA_W(8), .N_CH(1), .SIGNED(1'b1)) u_1 (
        .clk(clk), .rst(rst), .in_rdy(in_rdy_v[2]), .mode(sh_mode), .data_in(sh_data[7:0]),
        .ref_in(sh_ref), .out_ack(out_ack), .busy(b2), .out_rdy(r2), .result(res2),
        .min_idx(mn2), .max_idx(mx2), .err(e2), .done(d2));

    typedef struct {
        logic [12:0] pay;   // {result, min_idx, max_idx, err}
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   sel = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic        obs_busy, obs_rdy, obs_done;
    logic [12:0] obs_pay;

    always_comb begin
        case (sel)
            0: begin obs_busy = b0; obs_rdy = r0; obs_done = d0; obs_pay = {res0, mn0, mx0, e0}; end
            1: begin obs_busy = b1; obs_rdy = r1; obs_done = d1; obs_pay = {res1, mn1, mx1, e1}; end
            default: begin
                obs_busy = b2; obs_rdy = r2; obs_done = d2;
                obs_pay  = {6'b0, res2, 1'b0, mn2, 1'b0, mx2, e2};
            end
        endcase
    end

    // Reference model: integer compares on sign- or zero-extended words.
    function automatic exp_t model(input int s, input logic [1:0] md, input logic [31:0] d,
                                   input logic [7:0] r);
        exp_t       e;
        int         nch, v[4], rv, bv, mnv, mxv;
        bit         sgn;
        logic [7:0] res, w;
        logic [1:0] mn, mx;
        nch = (s == 2) ? 1 : 4;
        sgn = (s != 1);
        res = '0; mn = '0; mx = '0;
        rv  = sgn ? int'($signed(r)) : int'(r);
        bv  = (md == 2'b01) ? rv : 0;
        for (int i = 0; i < nch; i++) begin
            w    = d[i*8 +: 8];
            v[i] = sgn ? int'($signed(w)) : int'(w);
            if (md[1])          res[2*i +: 2] = 2'b11;
            else if (v[i] < bv) res[2*i +: 2] = 2'b01;
            else if (v[i] > bv) res[2*i +: 2] = 2'b10;
            else                res[2*i +: 2] = 2'b00;
        end
        mnv = v[0]; mxv = v[0];
        for (int i = 1; i < nch; i++) begin
            if (v[i] < mnv) begin mnv = v[i]; mn = 2'(i); end
            if (v[i] > mxv) begin mxv = v[i]; mx = 2'(i); end
        end
        e.pay = {res, mn, mx, md[1]};
        e.lat = nch + 2;
        return e;
    endfunction

    task automatic start(input int s, input logic [1:0] md, input logic [31:0] d,
                         input logic [7:0] r);
        @(negedge clk);
        sel         = s;
        sh_mode     = md;
        sh_data     = d;
        sh_ref      = r;
        in_rdy_v[s] = 1'b1;
        sb.push_back(model(s, md, d, r));
    endtask

    // Counts negedges from the in_rdy sampling edge until out_rdy is seen; -1 on timeout.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) in_rdy_v = '0;
            if (obs_rdy) begin
                lat = c;
                break;
            end
        end
    endtask

    // Acks at the current negedge; returns status in DONE and one cycle later.
    task automatic do_ack(output logic [15:0] s1, output logic [15:0] s2);
        out_ack = 1'b1;
        @(negedge clk);
        s1 = {obs_busy, obs_rdy, obs_done, obs_pay};
        out_ack = 1'b0;
        @(negedge clk);
        s2 = {obs_busy, obs_rdy, obs_done, obs_pay};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if ({obs_busy, obs_rdy, obs_done, obs_pay} !== 16'h0)
                $display("FAIL reset_state inst=%0d got=%h want=0", s,
                         {obs_busy, obs_rdy, obs_done, obs_pay});
            else n_pass++;
        end
    endtask

    task automatic test_job(input string nm, input int s, input logic [1:0] md,
                            input logic [31:0] d, input logic [7:0] r);
        int          lat;
        exp_t        e;
        logic [15:0] s1, s2;
        start(s, md, d, r);
        wait_rdy(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat || obs_pay !== e.pay)
            $display("FAIL %s_present lat=%0d pay=%b want lat=%0d pay=%b", nm, lat, obs_pay,
                     e.lat, e.pay);
        else n_pass++;
        do_ack(s1, s2);
        n_checks++;
        if (s1 !== {3'b101, 13'b0})
            $display("FAIL %s_done got=%h want=%h", nm, s1, {3'b101, 13'b0});
        else n_pass++;
        n_checks++;
        if (s2 !== 16'h0) $display("FAIL %s_idle got=%h want=0", nm, s2);
        else n_pass++;
    endtask

    task automatic test_hold();
        int          lat;
        exp_t        e;
        logic [15:0] s1, s2;
        start(0, 2'b01, $urandom, 8'($urandom));
        wait_rdy(lat);
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat || obs_pay !== e.pay)
            $display("FAIL hold_present lat=%0d pay=%b want lat=%0d pay=%b", lat, obs_pay,
                     e.lat, e.pay);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            in_rdy_v[0] = c[0] ? 1'b0 : 1'b1;
            sh_data     = $urandom;
            sh_mode     = 2'($urandom);
            sh_ref      = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if ({obs_rdy, obs_done, obs_pay} !== {2'b10, e.pay})
                $display("FAIL hold_stable cyc=%0d got=%h want=%h", c,
                         {obs_rdy, obs_done, obs_pay}, {2'b10, e.pay});
            else n_pass++;
        end
        in_rdy_v = '0;
        do_ack(s1, s2);
        n_checks++;
        if (s1 !== {3'b101, 13'b0}) $display("FAIL hold_done got=%h want=%h", s1, {3'b101, 13'b0});
        else n_pass++;
        n_checks++;
        if (s2 !== 16'h0) $display("FAIL hold_idle got=%h want=0", s2);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs_busy !== 1'b0) $display("FAIL hold_no_queue busy=%b want=0", obs_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic bad;
        start(0, 2'b00, 32'h01020304, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) in_rdy_v = '0;
        end
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({obs_busy, obs_rdy, obs_done, obs_pay} !== 16'h0)
            $display("FAIL rst_mid_clear got=%h want=0", {obs_busy, obs_rdy, obs_done, obs_pay});
        else n_pass++;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (obs_done !== 1'b0 || obs_busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL rst_mid_quiet got=%b want=0", bad);
        else n_pass++;
        test_job("rst_mid_rerun", 0, 2'b01, 32'hF0107F80, 8'hF0);
    endtask

    initial begin
        rst      = 1'b0;
        sh_mode  = '0;
        sh_data  = '0;
        sh_ref   = '0;
        out_ack  = 1'b0;
        in_rdy_v = '0;
        test_reset();
        test_job("t1_sign", 0, 2'b00, 32'h007F80FF, 8'h00);
        test_job("t2_ref", 0, 2'b01, 32'h100F1110, 8'h10);
        test_job("t3_unsigned", 1, 2'b00, 32'h800001FF, 8'h00);
        test_hold();
        test_reset_mid();
        test_job("t6_reserved", 0, 2'b10, 32'h80FF7F01, 8'h33);
        test_job("t6_nch1_res", 2, 2'b11, 32'h0000005A, 8'h00);
        test_job("nch1_sign", 2, 2'b00, 32'h00000080, 8'h00);
        test_job("unsigned_ref", 1, 2'b01, 32'h7F8081FF, 8'h80);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
